mem_store_forward_unit: RTL and testbench

Parametrised MEM-stage store-data forwarding unit; successor to the single-bit WB→MEM store-data mux.
Keeps a DEPTH-entry history of recent register-file writebacks. The store-data operand of the instruction in MEM resolves against the live WB write first, then against that history, newest entry first.
Covers stores held in MEM by stalls while several producers retire. Sits between EX/MEM pipeline register and data memory write port; also exports a saturating forward-event counter for the perf block.

---
 rtl/fwd_pkg.sv | 18 +
 rtl/fwd_history_buf.sv | 49 ++++
 rtl/mem_store_forward_unit.sv | 79 +++++++
 tb/tb_mem_store_forward_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared encodings and default widths for the MEM-stage store-data forwarding unit.
package fwd_pkg;

  localparam int FWD_DATA_W = 32;
  localparam int FWD_ADDR_W = 5;
  localparam int FWD_SRC_W  = 4;

  typedef logic [FWD_SRC_W-1:0] fwd_src_t;

  localparam fwd_src_t FWD_ORIG      = 4'd0;
  localparam fwd_src_t FWD_WB        = 4'd1;
  localparam fwd_src_t FWD_HIST_BASE = 4'd2;

  function automatic fwd_src_t hist_src(input int unsigned k);
    return FWD_HIST_BASE + fwd_src_t'(k);
  endfunction

endpackage

// File: rtl/fwd_history_buf.sv
// Writeback history shift buffer (entry 0 newest) with per-entry match vector.
// Match outputs are combinational from state; no backpressure, capture is unconditional.
module fwd_history_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             capture,
  input  logic                             clear,
  input  logic [ADDR_W-1:0]                cap_reg,
  input  logic [DATA_W-1:0]                cap_dat,
  input  logic [ADDR_W-1:0]                rt_reg,
  output logic [DEPTH-1:0]                 hit,
  output logic [DEPTH-1:0][DATA_W-1:0]     entry_dat
);

  logic [DEPTH-1:0]             entry_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] entry_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_vld <= '0;
      entry_reg <= '0;
      entry_dat <= '0;
    end else if (capture) begin
      // Shifted entries lose validity on clear; the write captured at this edge stays.
      entry_vld[0] <= 1'b1;
      entry_reg[0] <= cap_reg;
      entry_dat[0] <= cap_dat;
      for (int k = 1; k < DEPTH; k++) begin
        entry_vld[k] <= entry_vld[k-1] & ~clear;
        entry_reg[k] <= entry_reg[k-1];
        entry_dat[k] <= entry_dat[k-1];
      end
    end else if (clear) begin
      entry_vld <= '0;
    end
  end

  always_comb begin
    hit = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hit[k] = entry_vld[k] & (entry_reg[k] == rt_reg);
    end
  end

endmodule

// File: rtl/mem_store_forward_unit.sv
// MEM-stage store-data forwarding: live WB first, then writeback history newest-first.
// Zero-cycle combinational select; no backpressure, history only grows while MEM is stalled.
module mem_store_forward_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W = FWD_DATA_W,
  parameter int ADDR_W = FWD_ADDR_W,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              mem_valid,
  input  logic              mem_mem_write,
  input  logic [ADDR_W-1:0] mem_rt_reg,
  input  logic [DATA_W-1:0] mem_write_data,
  input  logic              mem_stall,
  output logic [DATA_W-1:0] store_data_fwd,
  output logic [3:0]        fwd_src,
  output logic [CNT_W-1:0]  fwd_count
);

  logic                         match_en;
  logic                         capture;
  logic                         wb_hit;
  logic [DEPTH-1:0]             hist_hit;
  logic [DEPTH-1:0][DATA_W-1:0] hist_dat;

  assign match_en = mem_valid & mem_mem_write & (mem_rt_reg != '0);
  assign capture  = wb_reg_write & (wb_write_reg != '0);
  assign wb_hit   = wb_reg_write & (wb_write_reg == mem_rt_reg);

  fwd_history_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_hist (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture),
    .clear     (~mem_stall),
    .cap_reg   (wb_write_reg),
    .cap_dat   (wb_write_data),
    .rt_reg    (mem_rt_reg),
    .hit       (hist_hit),
    .entry_dat (hist_dat)
  );

  always_comb begin
    store_data_fwd = mem_write_data;
    fwd_src        = FWD_ORIG;
    if (match_en) begin
      if (wb_hit) begin
        store_data_fwd = wb_write_data;
        fwd_src        = FWD_WB;
      end else begin
        // Walk oldest to newest so the lowest matching index is the one that sticks.
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (hist_hit[k]) begin
            store_data_fwd = hist_dat[k];
            fwd_src        = hist_src(unsigned'(k));
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_count <= '0;
    end else if (!mem_stall && match_en && (fwd_src != FWD_ORIG) && (fwd_count != '1)) begin
      fwd_count <= fwd_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_store_forward_unit.sv
// Scoreboard bench: driver pushes model predictions, negedge monitor compares DUT outputs.
module tb_mem_store_forward_unit;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 3;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              wb_reg_write;
  logic [ADDR_W-1:0] wb_write_reg;
  logic [DATA_W-1:0] wb_write_data;
  logic              mem_valid;
  logic              mem_mem_write;
  logic [ADDR_W-1:0] mem_rt_reg;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_stall;
  logic [DATA_W-1:0] store_data_fwd;
  logic [3:0]        fwd_src;
  logic [CNT_W-1:0]  fwd_count;

  mem_store_forward_unit #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .DEPTH (DEPTH), .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wb_reg_write   (wb_reg_write),
    .wb_write_reg   (wb_write_reg),
    .wb_write_data  (wb_write_data),
    .mem_valid      (mem_valid),
    .mem_mem_write  (mem_mem_write),
    .mem_rt_reg     (mem_rt_reg),
    .mem_write_data (mem_write_data),
    .mem_stall      (mem_stall),
    .store_data_fwd (store_data_fwd),
    .fwd_src        (fwd_src),
    .fwd_count      (fwd_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] dat;
    logic [3:0]        src;
    int                cnt;
    int                cyc;
  } exp_t;

  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } wb_ent_t;

  exp_t    exp_q[$];
  wb_ent_t hist[$];   // newest at index 0, holds only live entries
  int      m_count;
  int      cyc;
  int      checks = 0;
  int      passes = 0;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", name, c, act, exp);
  endtask

  // One pipeline cycle: drive, predict, push, then advance the model across the edge.
  task automatic step(input bit rst_v, input bit v, input bit mw, input logic [ADDR_W-1:0] rt,
                      input logic [DATA_W-1:0] mwd, input bit we, input logic [ADDR_W-1:0] wr,
                      input logic [DATA_W-1:0] wd, input bit st);
    exp_t e;
    bit   en;
    reset = rst_v; mem_valid = v; mem_mem_write = mw; mem_rt_reg = rt; mem_write_data = mwd;
    wb_reg_write = we; wb_write_reg = wr; wb_write_data = wd; mem_stall = st;
    if (rst_v) begin
      hist.delete();
      m_count = 0;
    end
    en = v && mw && (rt != 0);
    e.dat = mwd; e.src = 4'd0; e.cnt = m_count; e.cyc = cyc;
    if (en) begin
      if (we && wr == rt) begin
        e.dat = wd; e.src = 4'd1;
      end else begin
        foreach (hist[i]) begin
          if (hist[i].r == rt) begin
            e.dat = hist[i].d; e.src = 4'(2 + i);
            break;
          end
        end
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_v) begin
      if (!st && e.src != 0 && m_count < CNT_MAX) m_count++;
      if (!st) hist.delete();
      if (we && wr != 0) begin
        wb_ent_t n;
        n.r = wr; n.d = wd;
        hist.push_front(n);
        if (hist.size() > DEPTH) void'(hist.pop_back());
      end
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("store_data_fwd", e.cyc, store_data_fwd, e.dat);
        chk("fwd_src", e.cyc, {28'd0, fwd_src}, {28'd0, e.src});
        chk("fwd_count", e.cyc, {28'd0, fwd_count}, e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [ADDR_W-1:0] regs [6];
    regs = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd8, 5'd9};
    cyc = 0; m_count = 0;
    reset = 1'b1; wb_reg_write = 0; wb_write_reg = 0; wb_write_data = 0;
    mem_valid = 0; mem_mem_write = 0; mem_rt_reg = 0; mem_write_data = 0; mem_stall = 0;
    @(posedge clk); #1;

    // Reset state, then live-WB forward on an advancing store.
    step(1, 1, 1, 5'd8, 32'hDEAD_BEEF, 0, 5'd0, 32'h0, 0);
    step(0, 1, 1, 5'd8, 32'hDEAD_BEEF, 1, 5'd8, 32'h1234_5678, 0);
    // Stalled store collects $9=A, $9=B, $3=C, then resolves from history and retires.
    step(0, 1, 1, 5'd9, 32'h5555_0000, 1, 5'd9, 32'hA, 1);
    step(0, 1, 1, 5'd9, 32'h5555_0000, 1, 5'd9, 32'hB, 1);
    step(0, 1, 1, 5'd9, 32'h5555_0000, 1, 5'd3, 32'hC, 1);
    step(0, 1, 1, 5'd9, 32'h5555_0000, 0, 5'd0, 32'h0, 1);
    step(0, 1, 1, 5'd9, 32'h5555_0000, 0, 5'd0, 32'h0, 0);
    step(0, 1, 1, 5'd9, 32'h6666_0000, 0, 5'd0, 32'h0, 1);
    // Register 0 never forwarded nor captured.
    step(0, 1, 1, 5'd0, 32'h7777_0000, 1, 5'd0, 32'hFFFF_FFFF, 1);
    step(0, 1, 1, 5'd0, 32'h7777_0000, 0, 5'd0, 32'h0, 0);
    // Non-store and bubble with matching WB.
    step(0, 1, 0, 5'd8, 32'h8888_0000, 1, 5'd8, 32'h1111, 0);
    step(0, 0, 1, 5'd8, 32'h9999_0000, 1, 5'd8, 32'h2222, 0);
    // Overfill history with a duplicate, then async reset mid-stall.
    step(0, 1, 1, 5'd6, 32'h0, 1, 5'd5, 32'h50, 1);
    step(0, 1, 1, 5'd6, 32'h0, 1, 5'd6, 32'h60, 1);
    step(0, 1, 1, 5'd6, 32'h0, 1, 5'd7, 32'h70, 1);
    step(0, 1, 1, 5'd6, 32'h0, 1, 5'd6, 32'h61, 1);
    step(0, 1, 1, 5'd6, 32'hABCD_0000, 0, 5'd0, 32'h0, 1);
    step(1, 1, 1, 5'd6, 32'hABCD_0000, 0, 5'd0, 32'h0, 1);
    step(0, 1, 1, 5'd6, 32'hABCD_0000, 0, 5'd0, 32'h0, 0);
    // Twenty forwarded stores drive the counter into saturation.
    for (int i = 0; i < 20; i++) step(0, 1, 1, 5'd8, 32'h0, 1, 5'd8, $urandom, 0);
    step(0, 1, 1, 5'd8, 32'h0, 0, 5'd0, 32'h0, 0);
    // Random traffic with occasional mid-stream resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(9) != 0), ($urandom_range(9) < 7),
           regs[$urandom_range(5)], $urandom, ($urandom_range(9) < 6), regs[$urandom_range(5)],
           $urandom, ($urandom_range(9) < 6));
    end
    @(negedge clk); #1;
    chk("drain", cyc, exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
